// File: rtl/query_loader_if.sv
// query_loader_if: UART byte stream in, query/start bundle out to the engine.
// master drives bytes and engine_idle_in; slave is the loader.
interface query_loader_if #(
   parameter int DIM = 4
);
   logic [7:0]           byte_in;
   logic                 byte_valid_in;
   logic                 engine_idle_in;
   logic [DIM-1:0][31:0] query_out;
   logic [31:0]          vertex_id_out;
   logic [15:0]          k_out;
   logic                 start_out;
   logic                 busy_out;
   logic                 error_out;
   logic                 overrun_out;

   modport master (
      output byte_in, byte_valid_in, engine_idle_in,
      input  query_out, vertex_id_out, k_out,
      input  start_out, busy_out, error_out, overrun_out
   );

   modport slave (
      input  byte_in, byte_valid_in, engine_idle_in,
      output query_out, vertex_id_out, k_out,
      output start_out, busy_out, error_out, overrun_out
   );
endinterface

// File: rtl/query_loader.sv
// query_loader: parses UART frames into a query vector and starts the engine.
// Define QUERY_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte.
module query_loader #(
   parameter int DIM            = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic           clk_in,
   input logic           rst_in,
   query_loader_if.slave bus
);
   localparam int QB = 4 * DIM;
   localparam int BW = $clog2(QB + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]    SYNC   = 8'hA5;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] Q_LAST = BW'(QB - 1);

   typedef enum logic [2:0] {
      HUNT,
      VID,
      KVAL,
      QRY,
`ifdef QUERY_LOADER_CHECKSUM_EN
      CSUM,
`endif
      PEND
   } state_t;

   state_t               state;
   logic [BW-1:0]        bcnt;
   logic [TW-1:0]        tcnt;
   logic [31:0]          vid_sh;
   logic [15:0]          k_sh;
   logic [QB*8-1:0]      q_sh;
   logic [DIM-1:0][31:0] q_r;
   logic [31:0]          vid_r;
   logic [15:0]          k_r;
   logic                 start_r;
   logic                 error_r;
   logic                 overrun_r;
`ifdef QUERY_LOADER_CHECKSUM_EN
   logic [7:0]           csum;
`endif

   logic [7:0] b;
   logic       v;
   logic       sync_hit;

   assign b        = bus.byte_in;
   assign v        = bus.byte_valid_in;
   assign sync_hit = v && (b == SYNC);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= HUNT;
         bcnt      <= '0;
         tcnt      <= '0;
         vid_sh    <= '0;
         k_sh      <= '0;
         q_sh      <= '0;
         q_r       <= '0;
         vid_r     <= '0;
         k_r       <= '0;
         start_r   <= 1'b0;
         error_r   <= 1'b0;
         overrun_r <= 1'b0;
`ifdef QUERY_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         start_r   <= 1'b0;
         error_r   <= 1'b0;
         overrun_r <= 1'b0;
         unique case (state)
            HUNT: begin
               if (sync_hit) begin
                  state <= VID;
                  bcnt  <= '0;
                  tcnt  <= '0;
`ifdef QUERY_LOADER_CHECKSUM_EN
                  csum  <= '0;
`endif
               end
            end
            PEND: begin
               // a byte arriving on the commit edge belongs to the next frame
               if (bus.engine_idle_in) begin
                  q_r     <= q_sh;
                  vid_r   <= vid_sh;
                  k_r     <= k_sh;
                  start_r <= 1'b1;
                  state   <= sync_hit ? VID : HUNT;
                  bcnt    <= '0;
                  tcnt    <= '0;
`ifdef QUERY_LOADER_CHECKSUM_EN
                  csum    <= '0;
`endif
               end else if (v) begin
                  overrun_r <= 1'b1;
               end
            end
            default: begin
               if (v) begin
                  tcnt <= '0;
                  bcnt <= bcnt + 1'b1;
`ifdef QUERY_LOADER_CHECKSUM_EN
                  csum <= csum ^ b;
`endif
                  case (state)
                     VID: begin
                        vid_sh <= {b, vid_sh[31:8]};
                        if (bcnt == BW'(3)) begin
                           state <= KVAL;
                           bcnt  <= '0;
                        end
                     end
                     KVAL: begin
                        k_sh <= {b, k_sh[15:8]};
                        if (bcnt == BW'(1)) begin
                           state <= QRY;
                           bcnt  <= '0;
                        end
                     end
                     QRY: begin
                        q_sh <= {b, q_sh[QB*8-1:8]};
                        if (bcnt == Q_LAST) begin
                           bcnt <= '0;
`ifdef QUERY_LOADER_CHECKSUM_EN
                           state <= CSUM;
`else
                           state <= PEND;
`endif
                        end
                     end
`ifdef QUERY_LOADER_CHECKSUM_EN
                     CSUM: begin
                        bcnt <= '0;
                        if (b == csum) begin
                           state <= PEND;
                        end else begin
                           error_r <= 1'b1;
                           state   <= HUNT;
                        end
                     end
`endif
                     default: ;
                  endcase
               end else if (tcnt == T_LAST) begin
                  error_r <= 1'b1;
                  state   <= HUNT;
                  tcnt    <= '0;
               end else if (tcnt != '1) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.query_out     = q_r;
   assign bus.vertex_id_out = vid_r;
   assign bus.k_out         = k_r;
   assign bus.start_out     = start_r;
   assign bus.error_out     = error_r;
   assign bus.overrun_out   = overrun_r;
   assign bus.busy_out      = (state != HUNT);
endmodule

// File: tb/tb_query_loader.sv
// tb_query_loader: directed and random frames against a frame-level model.
// Define QUERY_LOADER_CHECKSUM_EN to run the checksum build (DIM=4).
module tb_query_loader;
`ifdef QUERY_LOADER_CHECKSUM_EN
   localparam int DIM = 4;
   localparam bit CK  = 1'b1;
`else
   localparam int DIM = 2;
   localparam bit CK  = 1'b0;
`endif
   localparam int TO   = 16;
   localparam int FLEN = 6 + 4 * DIM + (CK ? 1 : 0);

   typedef logic [7:0] bq_t[$];
   typedef logic [DIM-1:0][31:0] qv_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk_in = ~clk_in;

   query_loader_if #(.DIM(DIM)) bus ();

   query_loader #(
      .DIM(DIM),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int n_start = 0;
   int n_err = 0;
   int n_ovr = 0;

   bit         m_in;
   bit         m_pend;
   int         m_idle;
   logic [7:0] m_frm[$];
   qv_t        e_q;
   logic [31:0] e_vid;
   logic [15:0] e_k;
   bit e_start, e_err, e_ovr;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_in = 1'b0;
      m_pend = 1'b0;
      m_idle = 0;
      m_frm.delete();
      e_q = '0;
      e_vid = '0;
      e_k = '0;
      e_start = 1'b0;
      e_err = 1'b0;
      e_ovr = 1'b0;
   endtask

   task automatic open_frame();
      m_in = 1'b1;
      m_idle = 0;
      m_frm.delete();
   endtask

   // m_frm holds payload bytes (sync excluded) of the frame in flight
   task automatic model_edge(input bit v, input logic [7:0] b, input bit idle);
      logic [7:0] x;
      e_start = 1'b0;
      e_err = 1'b0;
      e_ovr = 1'b0;
      if (m_pend) begin
         if (idle) begin
            e_vid = {m_frm[3], m_frm[2], m_frm[1], m_frm[0]};
            e_k = {m_frm[5], m_frm[4]};
            for (int j = 0; j < DIM; j++)
               e_q[j] = {m_frm[9+4*j], m_frm[8+4*j], m_frm[7+4*j], m_frm[6+4*j]};
            e_start = 1'b1;
            m_pend = 1'b0;
            if (v && b == 8'hA5) open_frame();
         end else if (v) begin
            e_ovr = 1'b1;
         end
      end else if (m_in) begin
         if (v) begin
            m_frm.push_back(b);
            m_idle = 0;
            if (m_frm.size() == FLEN) begin
               m_in = 1'b0;
               x = 8'h00;
               for (int i = 0; i < FLEN - 1; i++) x = x ^ m_frm[i];
               if (!CK || x == m_frm[FLEN-1]) m_pend = 1'b1;
               else e_err = 1'b1;
            end
         end else begin
            m_idle = m_idle + 1;
            if (m_idle == TO) begin
               m_in = 1'b0;
               e_err = 1'b1;
            end
         end
      end else if (v && b == 8'hA5) begin
         open_frame();
      end
   endtask

   task automatic compare();
      chk("start", 128'(bus.start_out), 128'(e_start));
      chk("error", 128'(bus.error_out), 128'(e_err));
      chk("overrun", 128'(bus.overrun_out), 128'(e_ovr));
      chk("busy", 128'(bus.busy_out), 128'(m_in || m_pend));
      chk("vertex_id", 128'(bus.vertex_id_out), 128'(e_vid));
      chk("k", 128'(bus.k_out), 128'(e_k));
      chk("query", 128'(bus.query_out), 128'(e_q));
      n_start += int'(bus.start_out);
      n_err += int'(bus.error_out);
      n_ovr += int'(bus.overrun_out);
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit idle);
      @(negedge clk_in);
      bus.byte_valid_in = v;
      bus.byte_in = v ? b : 8'($urandom);
      bus.engine_idle_in = idle;
      @(posedge clk_in);
      model_edge(v, b, idle);
      #1;
      compare();
   endtask

   task automatic send(input bq_t f, input bit idle);
      foreach (f[i]) step(1'b1, f[i], idle);
   endtask

   task automatic build(input logic [31:0] vid, input logic [15:0] k,
                        input qv_t q, output bq_t f);
      logic [7:0] x;
      f.delete();
      f.push_back(8'hA5);
      for (int i = 0; i < 4; i++) f.push_back(vid[8*i +: 8]);
      for (int i = 0; i < 2; i++) f.push_back(k[8*i +: 8]);
      for (int j = 0; j < DIM; j++)
         for (int i = 0; i < 4; i++) f.push_back(q[j][8*i +: 8]);
      if (CK) begin
         x = 8'h00;
         for (int i = 1; i < f.size(); i++) x = x ^ f[i];
         f.push_back(x);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      bus.byte_valid_in = 1'b0;
      model_reset();
      #1;
      compare();
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   initial begin
      bq_t lit, f;
      qv_t q;
      logic [31:0] vid;
      logic [7:0] r;
      int s0, e0, o0, nz, gap;

      bus.byte_in = 8'h00;
      bus.byte_valid_in = 1'b0;
      bus.engine_idle_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      compare();
      @(negedge clk_in);
      rst_in = 1'b1;

`ifdef QUERY_LOADER_CHECKSUM_EN
      lit = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h08};
      s0 = n_start;
      e0 = n_err;
      send(lit, 1'b1);
      repeat (3) step(1'b0, 8'h00, 1'b1);
      chk("bad_csum_err", 128'(n_err - e0), 128'd1);
      chk("bad_csum_start", 128'(n_start - s0), 128'd0);
      chk("bad_csum_vid", 128'(bus.vertex_id_out), 128'd0);
      chk("bad_csum_q", 128'(bus.query_out), 128'd0);
      lit[23] = 8'h07;
      send(lit, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("a_start", 128'(bus.start_out), 128'd1);
      chk("a_q0", 128'(bus.query_out[0]), 128'd5);
      chk("a_q1", 128'(bus.query_out[1]), 128'd7);
      chk("a_q2", 128'(bus.query_out[2]), 128'd1);
      chk("a_q3", 128'(bus.query_out[3]), 128'd1);
`else
      lit = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h03, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
              8'h0B, 8'h00, 8'h00, 8'h00};
      send(lit, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("a_start", 128'(bus.start_out), 128'd1);
      chk("a_q0", 128'(bus.query_out[0]), 128'd10);
      chk("a_q1", 128'(bus.query_out[1]), 128'd11);
      chk("a_vid", 128'(bus.vertex_id_out), 128'd2);
      chk("a_k", 128'(bus.k_out), 128'd3);
`endif
      step(1'b0, 8'h00, 1'b1);
      chk("a_one_cycle", 128'(bus.start_out), 128'd0);

      // engine busy while frame completes; three bytes dropped while waiting
      for (int j = 0; j < DIM; j++) q[j] = $urandom;
      build(32'h1234_5678, 16'h0009, q, f);
      s0 = n_start;
      o0 = n_ovr;
      send(f, 1'b0);
      for (int i = 0; i < 50; i++)
         step(i == 5 || i == 10 || i == 15, 8'h3C, 1'b0);
      chk("ovr_count", 128'(n_ovr - o0), 128'd3);
      chk("ovr_no_start", 128'(n_start - s0), 128'd0);
      step(1'b0, 8'h00, 1'b1);
      chk("ovr_start", 128'(bus.start_out), 128'd1);
      chk("ovr_vid", 128'(bus.vertex_id_out), 128'h1234_5678);

      // inter-byte timeout
      e0 = n_err;
      step(1'b1, 8'hA5, 1'b1);
      step(1'b1, 8'h01, 1'b1);
      step(1'b1, 8'h00, 1'b1);
      repeat (TO) step(1'b0, 8'h00, 1'b1);
      chk("to_err", 128'(n_err - e0), 128'd1);
      chk("to_busy", 128'(bus.busy_out), 128'd0);
      build(32'h0000_0077, 16'h0011, q, f);
      send(f, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("to_start", 128'(bus.start_out), 128'd1);
      chk("to_vid", 128'(bus.vertex_id_out), 128'h77);

      // reset mid-frame
      build(32'hCAFE_0001, 16'h0100, q, f);
      for (int i = 0; i < 10; i++) step(1'b1, f[i], 1'b1);
      s0 = n_start;
      e0 = n_err;
      pulse_reset();
      chk("rst_vid", 128'(bus.vertex_id_out), 128'd0);
      chk("rst_q", 128'(bus.query_out), 128'd0);
      chk("rst_busy", 128'(bus.busy_out), 128'd0);
      repeat (TO + 2) step(1'b0, 8'h00, 1'b1);
      chk("rst_no_pulse", 128'((n_start - s0) + (n_err - e0)), 128'd0);
      send(f, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("rst_start", 128'(bus.start_out), 128'd1);
      chk("rst_vid2", 128'(bus.vertex_id_out), 128'hCAFE_0001);

      // random frames with noise, gaps, bad checksums and engine stalls
      for (int n = 0; n < 60; n++) begin
         for (int j = 0; j < DIM; j++) q[j] = $urandom;
         if ($urandom_range(0, 3) == 0) q[0][15:8] = 8'hA5;
         vid = $urandom;
         build(vid, 16'($urandom), q, f);
         if (CK && $urandom_range(0, 4) == 0) f[f.size()-1] = f[f.size()-1] ^ 8'h5A;
         nz = $urandom_range(0, 3);
         for (int i = 0; i < nz; i++) begin
            r = 8'($urandom);
            if (r == 8'hA5) r = 8'h5A;
            step(1'b1, r, 1'($urandom_range(0, 1)));
         end
         foreach (f[i]) begin
            gap = ($urandom_range(0, 29) == 0) ? $urandom_range(14, 18)
                                               : $urandom_range(0, 2);
            repeat (gap) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
            step(1'b1, f[i], 1'($urandom_range(0, 1)));
         end
         repeat ($urandom_range(0, 20)) begin
            r = 8'($urandom);
            if (r == 8'hA5) r = 8'h3C;
            step($urandom_range(0, 5) == 0, r, $urandom_range(0, 2) == 0);
         end
         repeat (TO + 4) step(1'b0, 8'h00, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
